// File: rtl/memalu_pkg.sv
// Shared types for the MEMALU arbiter.
//   memalu_op_t        : operation code driven to the shared MEMALU
//   MEMALU_OFFSET_BIAS : bias subtracted by the MEMALU for OFFSET ops
//   arb_state_t        : arbiter FSM states
package memalu_pkg;

    typedef enum logic [1:0] {
        OpAdd    = 2'd0,
        OpIncr   = 2'd1,
        OpOffset = 2'd2
    } memalu_op_t;

    localparam int unsigned MEMALU_OFFSET_BIAS = 'h7F;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StExec = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   valid      : request strobes
//   last_grant : index of the most recently served requester
//   grant      : one-hot winner, searching from last_grant+1 upward with wrap;
//                all zero when nothing is valid
module rr_arbiter #(
    parameter int unsigned NREQ = 3,
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IdxW-1:0] last_grant,
    output logic [NREQ-1:0] grant
);

    logic            found;
    logic [IdxW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = IdxW'((32'(last_grant) + off) % NREQ);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memalu_arbiter.sv
// Round-robin arbiter sharing one external MEMALU among NREQ requesters.
//   clk, rst             : clock and synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake, ready is one-hot in IDLE
//   req_op/a/b/len       : per-requester operation, operands and beat count
//   alu_a/alu_b/alu_mode : operands and op driven to the MEMALU in EXEC
//   alu_control          : MEMALU bus-drive enable (high in EXEC)
//   alu_out              : MEMALU result, captured at each EXEC edge
//   resp_valid/resp_data : one-cycle one-hot pulse and registered beat result
//   busy                 : high whenever not IDLE
// Build option: define MEMALU_ARBITER_BURST_EN to enable multi-beat bursts
// (beats after the first chain INCR on the previous result).
module memalu_arbiter
    import memalu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  memalu_op_t [NREQ-1:0]      req_op,
    input  logic [NREQ-1:0][WIDTH-1:0] req_a,
    input  logic [NREQ-1:0][WIDTH-1:0] req_b,
    input  logic [NREQ-1:0][3:0]       req_len,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output memalu_op_t                 alu_mode,
    output logic                       alu_control,
    input  logic [WIDTH-1:0]           alu_out,
    output logic [NREQ-1:0]            resp_valid,
    output logic [WIDTH-1:0]           resp_data,
    output logic                       busy
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state_q, state_d;
    logic [IdxW-1:0]  id_q, last_grant_q, grant_idx;
    memalu_op_t       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [NREQ-1:0]  grant, resp_valid_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             accept, last_beat;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // grant only ever selects a valid requester, so ready alone means accept
    assign req_ready = (state_q == StIdle) ? grant : '0;
    assign accept    = |req_ready;
    assign busy      = (state_q != StIdle);

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = IdxW'(i);
        end
    end

`ifdef MEMALU_ARBITER_BURST_EN
    logic [3:0] beats_left_q;  // beats still to run after the current one

    assign last_beat = (beats_left_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_left_q <= 4'd0;
        end else if (accept) begin
            // a length of 0 behaves as a single beat
            beats_left_q <= (req_len[grant_idx] == 4'd0) ? 4'd0 : req_len[grant_idx] - 4'd1;
        end else if (state_q == StExec && !last_beat) begin
            beats_left_q <= beats_left_q - 4'd1;
        end
    end
`else
    logic unused_len;

    assign last_beat  = 1'b1;
    assign unused_len = ^req_len;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  if (last_beat) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= IdxW'(NREQ - 1);
            id_q         <= '0;
            op_q         <= OpAdd;
            a_q          <= '0;
            b_q          <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= '0;
            if (accept) begin
                id_q <= grant_idx;
                op_q <= req_op[grant_idx];
                a_q  <= req_a[grant_idx];
                b_q  <= req_b[grant_idx];
            end
            if (state_q == StExec) begin
                resp_data_q  <= alu_out;
                resp_valid_q <= NREQ'(1) << id_q;
                if (last_beat) begin
                    last_grant_q <= id_q;
                end else begin
                    // next beat increments the result just produced
                    a_q  <= alu_out;
                    op_q <= OpIncr;
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

    always_comb begin
        alu_control = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_mode    = OpAdd;
        if (state_q == StExec) begin
            alu_control = 1'b1;
            alu_a       = a_q;
            alu_b       = b_q;
            alu_mode    = op_q;
        end
    end

endmodule

// File: tb/tb_memalu_arbiter.sv
// Self-checking bench for memalu_arbiter: behavioural MEMALU, transaction-level
// timeline model of expected grants/responses, directed cases and random traffic.
module tb_memalu_arbiter;
    import memalu_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREQ  = 3;
`ifdef MEMALU_ARBITER_BURST_EN
    localparam bit BurstEn = 1'b1;
`else
    localparam bit BurstEn = 1'b0;
`endif
    localparam int ExpBeats = BurstEn ? 4 : 1;
    localparam logic [WIDTH-1:0] ExpLast = BurstEn ? 16'h0002 : 16'hFFFF;

    logic                       clk;
    logic                       rst;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    memalu_op_t [NREQ-1:0]      req_op;
    logic [NREQ-1:0][WIDTH-1:0] req_a;
    logic [NREQ-1:0][WIDTH-1:0] req_b;
    logic [NREQ-1:0][3:0]       req_len;
    logic [WIDTH-1:0]           alu_a;
    logic [WIDTH-1:0]           alu_b;
    memalu_op_t                 alu_mode;
    logic                       alu_control;
    logic [WIDTH-1:0]           alu_out;
    logic [NREQ-1:0]            resp_valid;
    logic [WIDTH-1:0]           resp_data;
    logic                       busy;

    memalu_arbiter #(
        .WIDTH(WIDTH),
        .NREQ (NREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_len     (req_len),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_mode    (alu_mode),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_fn(input memalu_op_t op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [31:0] r;
        case (op)
            OpAdd:    r = 32'(a) + 32'(b);
            OpIncr:   r = 32'(a) + 32'd1;
            OpOffset: r = 32'(a) + 32'(b) - 32'(MEMALU_OFFSET_BIAS);
            default:  r = 32'd0;
        endcase
        return r[WIDTH-1:0];
    endfunction

    // Shared MEMALU: drives its result only while enabled
    always_comb alu_out = alu_control ? alu_fn(alu_mode, alu_a, alu_b) : '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int               cyc;
        memalu_op_t       mode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               chk_b;
    } exec_t;

    typedef struct {
        int               cyc;
        int               id;
        logic [WIDTH-1:0] data;
    } resp_t;

    exec_t            exec_q[$];
    resp_t            resp_q[$];
    int               cyc;
    int               free_at;
    int               lg_m;
    int               win_m;
    logic             busy_e;
    logic [NREQ-1:0]  ready_e;
    logic [WIDTH-1:0] rd_m;
    logic [NREQ-1:0]  last_ready;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int lg);
        for (int k = 1; k <= int'(NREQ); k++) begin
            int i;
            i = (lg + k) % int'(NREQ);
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exec_q.delete();
        resp_q.delete();
        free_at = 0;
        lg_m    = int'(NREQ) - 1;
        rd_m    = '0;
    endtask

    task automatic check_cycle();
        exec_t           e;
        resp_t           r;
        logic [NREQ-1:0] rv_e;
        busy_e  = (cyc < free_at);
        win_m   = rr_pick(req_valid, lg_m);
        ready_e = '0;
        if (!busy_e && win_m >= 0) ready_e = NREQ'(1) << win_m;
        check_eq("req_ready", 32'(req_ready), 32'(ready_e));
        check_eq("busy", 32'(busy), 32'(busy_e));
        if (exec_q.size() != 0 && exec_q[0].cyc == cyc) begin
            e = exec_q.pop_front();
            check_eq("alu_control", 32'(alu_control), 32'd1);
            check_eq("alu_mode", 32'(alu_mode), 32'(e.mode));
            check_eq("alu_a", 32'(alu_a), 32'(e.a));
            if (e.chk_b) check_eq("alu_b", 32'(alu_b), 32'(e.b));
        end else begin
            check_eq("alu_control_idle", 32'(alu_control), 32'd0);
            check_eq("alu_a_idle", 32'(alu_a), 32'd0);
            check_eq("alu_b_idle", 32'(alu_b), 32'd0);
            check_eq("alu_mode_idle", 32'(alu_mode), 32'd0);
        end
        rv_e = '0;
        if (resp_q.size() != 0 && resp_q[0].cyc == cyc) begin
            r    = resp_q.pop_front();
            rv_e = NREQ'(1) << r.id;
            rd_m = r.data;
        end
        check_eq("resp_valid", 32'(resp_valid), 32'(rv_e));
        check_eq("resp_data", 32'(resp_data), 32'(rd_m));
        last_ready = req_ready;
    endtask

    task automatic model_accept();
        exec_t            e;
        resp_t            r;
        int               n;
        logic [WIDTH-1:0] res, prev;
        if (busy_e || win_m < 0) return;
        n = 1;
        if (BurstEn) n = (req_len[win_m] == 4'd0) ? 1 : int'(req_len[win_m]);
        res = alu_fn(req_op[win_m], req_a[win_m], req_b[win_m]);
        prev = '0;
        for (int k = 1; k <= n; k++) begin
            e.cyc   = cyc + k;
            e.mode  = (k == 1) ? req_op[win_m] : OpIncr;
            e.a     = (k == 1) ? req_a[win_m] : prev;
            e.b     = req_b[win_m];
            e.chk_b = (k == 1);
            exec_q.push_back(e);
            r.cyc  = cyc + k + 1;
            r.id   = win_m;
            r.data = res;
            resp_q.push_back(r);
            prev = res;
            res  = alu_fn(OpIncr, res, '0);
        end
        free_at = cyc + 1 + n;
        lg_m    = win_m;
    endtask

    // One clock: drive, check at negedge, advance model, return #1 after posedge
    task automatic step(input logic r, input logic [NREQ-1:0] v);
        rst       = r;
        req_valid = v;
        @(negedge clk);
        check_cycle();
        if (r) model_reset();
        else model_accept();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int i, input memalu_op_t op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [3:0] len);
        req_op[i]  = op;
        req_a[i]   = a;
        req_b[i]   = b;
        req_len[i] = len;
    endtask

    logic [NREQ-1:0]  grants[$];
    logic [WIDTH-1:0] first_d, last_d;
    int               pulses;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < int'(NREQ); i++) set_req(i, OpAdd, '0, '0, 4'd0);
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        step(1'b1, '0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_data", 32'(resp_data), 32'd0);
        check_eq("rst_alu_control", 32'(alu_control), 32'd0);

        // Single ADD
        set_req(0, OpAdd, 16'h1000, 16'h0020, 4'd0);
        step(1'b0, 3'b001);
        check_eq("add_ready", 32'(last_ready), 32'h1);
        check_eq("add_ctrl", 32'(alu_control), 32'd1);
        check_eq("add_mode", 32'(alu_mode), 32'(OpAdd));
        step(1'b0, '0);
        check_eq("add_rv", 32'(resp_valid), 32'h1);
        check_eq("add_rd", 32'(resp_data), 32'h1020);
        step(1'b0, '0);

        // OFFSET
        set_req(1, OpOffset, 16'h2000, 16'h0010, 4'd0);
        step(1'b0, 3'b010);
        step(1'b0, '0);
        check_eq("off_rv", 32'(resp_valid), 32'h2);
        check_eq("off_rd", 32'(resp_data), 32'h1F91);

        // Round robin from reset with all requesters held valid
        step(1'b1, '0);
        for (int i = 0; i < int'(NREQ); i++) set_req(i, OpAdd, WIDTH'(i * 16), 16'h0001, 4'd0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'b111);
            if (last_ready != '0) grants.push_back(last_ready);
        end
        check_eq("rr_count", 32'(grants.size()), 32'd4);
        check_eq("rr_g0", 32'(grants[0]), 32'h1);
        check_eq("rr_g1", 32'(grants[1]), 32'h2);
        check_eq("rr_g2", 32'(grants[2]), 32'h4);
        check_eq("rr_g3", 32'(grants[3]), 32'h1);
        step(1'b0, '0);
        step(1'b0, '0);

        // Burst INCR from 0xFFFE, len 4
        set_req(2, OpIncr, 16'hFFFE, 16'h0000, 4'd4);
        step(1'b0, 3'b100);
        pulses  = 0;
        first_d = '0;
        last_d  = '0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, '0);
            if (resp_valid[2]) begin
                if (pulses == 0) first_d = resp_data;
                last_d = resp_data;
                pulses++;
            end
        end
        check_eq("burst_pulses", 32'(pulses), 32'(ExpBeats));
        check_eq("burst_first", 32'(first_d), 32'hFFFF);
        check_eq("burst_last", 32'(last_d), 32'(ExpLast));

        // Reset during beat 2 of a len-4 burst
        set_req(0, OpAdd, 16'h0100, 16'h0001, 4'd4);
        step(1'b0, 3'b001);
        step(1'b0, '0);
        step(1'b1, '0);
        check_eq("mid_rst_ctrl", 32'(alu_control), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0);
            if (resp_valid != '0) pulses++;
        end
        check_eq("mid_rst_pulses", 32'(pulses), 32'd0);
        set_req(1, OpAdd, 16'h0003, 16'h0004, 4'd0);
        step(1'b0, 3'b010);
        step(1'b0, '0);
        check_eq("post_rst_rv", 32'(resp_valid), 32'h2);
        check_eq("post_rst_rd", 32'(resp_data), 32'h0007);

        // Random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                set_req(i, memalu_op_t'($urandom_range(0, 2)), WIDTH'($urandom),
                        WIDTH'($urandom), 4'($urandom_range(0, 5)));
            end
            step(($urandom_range(0, 59) == 0), NREQ'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memalu_arbiter.md
MEMALU_ARBITER -- requirements
Module: memalu_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, address/operand width in bits.
REQ-002 Parameter NREQ, default 3, number of requesters.
REQ-003 Reset scheme SHALL be one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  NREQ  per-requester request strobe.
REQ-007 req_ready  output  NREQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-008 req_op  input  NREQ x 2  memalu_op_t per requester (ADD, INCR, OFFSET).
REQ-009 req_a, req_b  input  NREQ x WIDTH  operands per requester.
REQ-010 req_len  input  NREQ x 4  burst beat count per requester; 0 is treated as 1.
REQ-011 alu_a, alu_b  output  WIDTH  operands driven to the shared MEMALU.
REQ-012 alu_mode  output  2  memalu_op_t driven to MEMALU.
REQ-013 alu_control  output  1  MEMALU bus-drive enable.
REQ-014 alu_out  input  WIDTH  shared result bus, valid only while alu_control=1.
REQ-015 resp_valid  output  NREQ  one-hot, one-cycle pulse per completed beat.
REQ-016 resp_data  output  WIDTH  registered beat result.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE and EXEC; req_ready SHALL be nonzero only in IDLE.
REQ-019 In IDLE, req_ready SHALL be combinationally one-hot to the round-robin winner among valid requesters, searching from last_grant+1 upward, wrapping modulo NREQ; all zero when no req_valid.
REQ-020 On acceptance, the block SHALL latch id, op, a, b and the beat count, and move to EXEC next cycle.
REQ-021 In EXEC, alu_control SHALL be 1 and alu_a/alu_b/alu_mode SHALL be driven from the latched values; outside EXEC, alu_control=0 and alu_a, alu_b, alu_mode SHALL be 0.
REQ-022 At each EXEC clock edge, alu_out SHALL be captured into resp_data and resp_valid[id] SHALL pulse in the following cycle.
REQ-023 Latency: request accepted in cycle N -> EXEC in N+1 -> resp_valid in N+2; single-beat throughput is one op per 2 cycles.
REQ-024 Beat 1 SHALL use the latched op; beats 2..len SHALL use INCR with alu_a equal to the previous beat's result, one beat per cycle, with no IDLE gap.
REQ-025 After the last beat, state SHALL return to IDLE and last_grant SHALL be updated to id.
REQ-026 Arithmetic wraps modulo 2^WIDTH; the block does not inspect or check alu_out.
REQ-027 req_valid deasserting after acceptance SHALL NOT affect the running operation; simultaneous valids SHALL be served strictly by the round-robin order.

Reset
REQ-028 Reset SHALL set state=IDLE, req_ready computed from IDLE, resp_valid=0, resp_data=0, busy=0, alu_control=0, alu_a/alu_b/alu_mode=0, last_grant=NREQ-1.
REQ-029 Reset asserted mid-burst SHALL abandon the operation; no further resp_valid pulses SHALL be produced for it.

Configuration
REQ-030 Macro MEMALU_ARBITER_BURST_EN, when defined, SHALL enable REQ-024 multi-beat bursts.
REQ-031 Without MEMALU_ARBITER_BURST_EN, req_len SHALL be ignored, every request SHALL be one beat, and the beat counter logic SHALL be absent.

Structure
REQ-032 Package memalu_pkg SHALL hold memalu_op_t, constant MEMALU_OFFSET_BIAS = 'h7F, and the arbiter state enum.
REQ-033 Round-robin selection SHALL be a sub-module named rr_arbiter, parameterised by NREQ.

Verification
REQ-034 Single ADD: req0 valid, a=0x1000, b=0x0020 -> req_ready[0] in cycle N, alu_control=1 and alu_mode=ADD in N+1, resp_valid[0] with resp_data=0x1020 in N+2.
REQ-035 OFFSET: req1 a=0x2000, b=0x0010 -> resp_data=0x1F91 (0x2000+0x10-0x7F).
REQ-036 Round robin: req0, req1 and req2 held valid from reset -> grant order 0,1,2,0; no requester is granted twice while another waits.
REQ-037 Burst (BURST_EN): req2 INCR, a=0xFFFE, len=4 -> four consecutive resp_valid[2] pulses with resp_data 0xFFFF, 0x0000, 0x0001, 0x0002; busy high throughout, req_ready all zero throughout.
REQ-038 Reset mid-burst: rst asserted during beat 2 of a len=4 burst -> next cycle state IDLE, alu_control=0, no further resp_valid; a later request completes normally.
REQ-039 Without BURST_EN: same stimulus as REQ-037 -> exactly one resp_valid[2], resp_data=0xFFFF.
